// File: rtl/motion_update_sequencer.sv
// Walks every cell's velocity cache once per pass: reads each cell's particle count,
// then every entry, and rebroadcasts the entries tagged with their destination cell.
module motion_update_sequencer #(
    parameter int DATA_WIDTH    = 32,
    parameter int ADDR_WIDTH    = 8,
    parameter int CELL_ID_WIDTH = 4,
    parameter int X_DIM         = 4,
    parameter int Y_DIM         = 4,
    parameter int Z_DIM         = 4,
    parameter int FLIP_WAIT     = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       start,
    output logic                       out_busy,
    output logic                       done,
    output logic                       out_motion_update_enable,
    output logic [3*CELL_ID_WIDTH-1:0] out_rd_cell_id,
    output logic [ADDR_WIDTH-1:0]      out_read_address,
    output logic                       out_rden,
    input  logic [3*DATA_WIDTH-1:0]    in_particle_info,
    input  logic [3*CELL_ID_WIDTH-1:0] in_dst_cell,
    output logic [3*DATA_WIDTH-1:0]    out_data,
    output logic [3*CELL_ID_WIDTH-1:0] out_data_dst_cell,
    output logic                       out_data_valid
);

    localparam int CW    = CELL_ID_WIDTH;
    localparam int CNT_W = (FLIP_WAIT < 4) ? 2 : $clog2(FLIP_WAIT + 1);

    localparam logic [CW-1:0]         ONE      = CW'(1);
    localparam logic [CW-1:0]         X_MAX    = CW'(X_DIM);
    localparam logic [CW-1:0]         Y_MAX    = CW'(Y_DIM);
    localparam logic [CW-1:0]         Z_MAX    = CW'(Z_DIM);
    localparam logic [ADDR_WIDTH-1:0] ADDR_0   = {ADDR_WIDTH{1'b0}};
    localparam logic [ADDR_WIDTH-1:0] ADDR_1   = ADDR_WIDTH'(1);
    localparam logic [CNT_W-1:0]      CNT_0    = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0]      CNT_1    = CNT_W'(1);
    localparam logic [CNT_W-1:0]      CNT_FLIP = CNT_W'(FLIP_WAIT - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_READ_NUM,
        S_WAIT_NUM,
        S_READ_PARTICLES,
        S_DRAIN,
        S_NEXT_CELL,
        S_FINISH,
        S_DONE
    } state_t;

    state_t                state;
    logic [ADDR_WIDTH-1:0] num;
    logic [CNT_W-1:0]      cnt;
    logic [CW-1:0]         cell_x;
    logic [CW-1:0]         cell_y;
    logic [CW-1:0]         cell_z;
    logic                  rd_q1;
    logic                  rd_q2;
    logic                  last_cell;

    assign out_rd_cell_id = {cell_x, cell_y, cell_z};
    assign last_cell      = (cell_x == X_MAX) && (cell_y == Y_MAX) && (cell_z == Z_MAX);

    // Pass sequencer: cell walk, read issue and enable/done handshake.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state                    <= S_IDLE;
            num                      <= ADDR_0;
            cnt                      <= CNT_0;
            cell_x                   <= ONE;
            cell_y                   <= ONE;
            cell_z                   <= ONE;
            out_busy                 <= 1'b0;
            done                     <= 1'b0;
            out_motion_update_enable <= 1'b0;
            out_rden                 <= 1'b0;
            out_read_address         <= ADDR_0;
        end else begin
            done <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (start) begin
                        state                    <= S_READ_NUM;
                        out_busy                 <= 1'b1;
                        out_motion_update_enable <= 1'b1;
                        cell_x                   <= ONE;
                        cell_y                   <= ONE;
                        cell_z                   <= ONE;
                        out_rden                 <= 1'b1;
                        out_read_address         <= ADDR_0;
                    end else begin
                        state <= S_IDLE;
                    end
                end
                S_READ_NUM: begin
                    out_rden <= 1'b0;
                    cnt      <= CNT_0;
                    state    <= S_WAIT_NUM;
                end
                S_WAIT_NUM: begin
                    // Count word arrives two cycles after the address-0 read.
                    if (cnt == CNT_1) begin
                        cnt <= CNT_0;
                        num <= in_particle_info[ADDR_WIDTH-1:0];
                        if (in_particle_info[ADDR_WIDTH-1:0] == ADDR_0) begin
                            state <= S_NEXT_CELL;
                        end else begin
                            state            <= S_READ_PARTICLES;
                            out_rden         <= 1'b1;
                            out_read_address <= ADDR_1;
                        end
                    end else begin
                        cnt <= cnt + CNT_1;
                    end
                end
                S_READ_PARTICLES: begin
                    if (out_read_address == num) begin
                        out_rden         <= 1'b0;
                        out_read_address <= ADDR_0;
                        cnt              <= CNT_0;
                        state            <= S_DRAIN;
                    end else begin
                        out_read_address <= out_read_address + ADDR_1;
                    end
                end
                S_DRAIN: begin
                    if (cnt == CNT_1) begin
                        cnt   <= CNT_0;
                        state <= S_NEXT_CELL;
                    end else begin
                        cnt <= cnt + CNT_1;
                    end
                end
                S_NEXT_CELL: begin
                    if (last_cell) begin
                        out_motion_update_enable <= 1'b0;
                        cell_x                   <= ONE;
                        cell_y                   <= ONE;
                        cell_z                   <= ONE;
                        cnt                      <= CNT_0;
                        state                    <= S_FINISH;
                    end else begin
                        // z is the innermost loop, x the outermost.
                        if (cell_z == Z_MAX) begin
                            cell_z <= ONE;
                            if (cell_y == Y_MAX) begin
                                cell_y <= ONE;
                                cell_x <= cell_x + ONE;
                            end else begin
                                cell_y <= cell_y + ONE;
                            end
                        end else begin
                            cell_z <= cell_z + ONE;
                        end
                        out_rden         <= 1'b1;
                        out_read_address <= ADDR_0;
                        state            <= S_READ_NUM;
                    end
                end
                S_FINISH: begin
                    // Caches commit counts and flip buffers while the enable is low.
                    if (cnt == CNT_FLIP) begin
                        cnt   <= CNT_0;
                        done  <= 1'b1;
                        state <= S_DONE;
                    end else begin
                        cnt <= cnt + CNT_1;
                    end
                end
                S_DONE: begin
                    out_busy <= 1'b0;
                    state    <= S_IDLE;
                end
                default: begin
                    state                    <= S_IDLE;
                    out_busy                 <= 1'b0;
                    out_motion_update_enable <= 1'b0;
                    out_rden                 <= 1'b0;
                    out_read_address         <= ADDR_0;
                end
            endcase
        end
    end

    // Broadcast pipeline: valid is a particle read delayed to line up with the registered data.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_q1             <= 1'b0;
            rd_q2             <= 1'b0;
            out_data_valid    <= 1'b0;
            out_data          <= (3*DATA_WIDTH)'(0);
            out_data_dst_cell <= (3*CELL_ID_WIDTH)'(0);
        end else begin
            rd_q1          <= out_rden && (out_read_address != ADDR_0);
            rd_q2          <= rd_q1;
            out_data_valid <= rd_q2;
            if (rd_q2) begin
                out_data          <= in_particle_info;
                out_data_dst_cell <= in_dst_cell;
            end else begin
                out_data          <= (3*DATA_WIDTH)'(0);
                out_data_dst_cell <= (3*CELL_ID_WIDTH)'(0);
            end
        end
    end

endmodule

// File: tb/tb_motion_update_sequencer.sv
// Randomized bench for motion_update_sequencer: behavioural cache memory plus a
// per-pass reference queue of expected broadcasts, visit order and cycle count.
module tb_motion_update_sequencer;

    localparam int FW     = 4;
    localparam int NCELLS = 64;

    logic         clk = 1'b0;
    logic         rst;
    logic         start;
    logic         out_busy;
    logic         done;
    logic         out_motion_update_enable;
    logic [11:0]  out_rd_cell_id;
    logic [7:0]   out_read_address;
    logic         out_rden;
    logic [95:0]  in_particle_info;
    logic [11:0]  in_dst_cell;
    logic [95:0]  out_data;
    logic [11:0]  out_data_dst_cell;
    logic         out_data_valid;

    int n_checks = 0;
    int n_errors = 0;

    logic [95:0] mem  [0:NCELLS-1][0:255];
    logic [11:0] dstm [0:NCELLS-1][0:255];
    int          counts [NCELLS];
    logic [95:0] s1_data;
    logic [11:0] s1_dst;

    motion_update_sequencer dut (
        .clk                      (clk),
        .rst                      (rst),
        .start                    (start),
        .out_busy                 (out_busy),
        .done                     (done),
        .out_motion_update_enable (out_motion_update_enable),
        .out_rd_cell_id           (out_rd_cell_id),
        .out_read_address         (out_read_address),
        .out_rden                 (out_rden),
        .in_particle_info         (in_particle_info),
        .in_dst_cell              (in_dst_cell),
        .out_data                 (out_data),
        .out_data_dst_cell        (out_data_dst_cell),
        .out_data_valid           (out_data_valid)
    );

    always #5 clk = ~clk;

    function automatic int cidx(input logic [11:0] c);
        return ((int'(c[11:8]) - 1) * 16 + (int'(c[7:4]) - 1) * 4 + (int'(c[3:0]) - 1)) & 63;
    endfunction

    // Cache memory model: readout two cycles after the read enable.
    always @(posedge clk) begin
        if (out_rden) begin
            s1_data <= mem[cidx(out_rd_cell_id)][out_read_address];
            s1_dst  <= dstm[cidx(out_rd_cell_id)][out_read_address];
        end else begin
            s1_data <= 96'h0;
            s1_dst  <= 12'h0;
        end
        in_particle_info <= s1_data;
        in_dst_cell      <= s1_dst;
    end

    task automatic check_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic fill_mem();
        logic [95:0] w;
        for (int c = 0; c < NCELLS; c++) begin
            w      = {$urandom, $urandom, $urandom};
            w[7:0] = 8'(counts[c]);
            mem[c][0]  = w;
            dstm[c][0] = 12'($urandom);
            for (int i = 1; i < 256; i++) begin
                mem[c][i]  = {$urandom, $urandom, $urandom};
                dstm[c][i] = 12'($urandom);
            end
        end
    endtask

    task automatic run_pass(input bit second_start);
        logic [107:0] exp_bc[$];
        logic [11:0]  exp_cells[$];
        logic [107:0] e;
        logic [11:0]  ec;
        int sum, total, expect_cycles, done_cycle, done_cnt, en_cnt, last_hi, vld_cnt, idx;
        sum = 0; total = 0; done_cycle = -1; done_cnt = 0; en_cnt = 0; last_hi = -1; vld_cnt = 0;
        for (int x = 1; x <= 4; x++)
            for (int y = 1; y <= 4; y++)
                for (int z = 1; z <= 4; z++) begin
                    idx = (x - 1) * 16 + (y - 1) * 4 + (z - 1);
                    exp_cells.push_back({4'(x), 4'(y), 4'(z)});
                    sum += counts[idx] + 6 - ((counts[idx] == 0) ? 2 : 0);
                    total += counts[idx];
                    for (int i = 1; i <= counts[idx]; i++)
                        exp_bc.push_back({dstm[idx][i], mem[idx][i]});
                end
        expect_cycles = 1 + sum + FW;
        @(negedge clk);
        check_eq("idle_before_start", out_busy, 1'b0);
        start = 1'b1;
        for (int n = 1; n <= expect_cycles + 40; n++) begin
            @(negedge clk);
            if (done_cycle < 0) check_eq("busy_in_pass", out_busy, 1'b1);
            else if (n > done_cycle) check_eq("busy_after_done", out_busy, 1'b0);
            if (out_motion_update_enable) begin
                en_cnt++;
                last_hi = n;
            end
            if (out_rden && out_read_address == 8'h0) begin
                if (exp_cells.size() == 0) check_eq("extra_cell_read", out_rd_cell_id, 12'h0);
                else begin
                    ec = exp_cells.pop_front();
                    check_eq("cell_order", out_rd_cell_id, ec);
                end
            end
            if (out_data_valid) begin
                vld_cnt++;
                if (exp_bc.size() == 0) check_eq("extra_broadcast", 1'b1, 1'b0);
                else begin
                    e = exp_bc.pop_front();
                    check_eq("broadcast", {out_data_dst_cell, out_data}, e);
                end
                if (out_motion_update_enable == 1'b0) check_eq("bc_before_en_fall", 1'b0, 1'b1);
            end else begin
                check_eq("idle_bus_zero", {out_data_dst_cell, out_data}, 108'h0);
            end
            if (done) begin
                done_cnt++;
                if (done_cycle < 0) done_cycle = n;
            end
            start = 1'b0;
            if (second_start && n == 10) start = 1'b1;
            if (done_cycle > 0 && n >= done_cycle + 15) break;
        end
        start = 1'b0;
        check_eq("done_cycle", done_cycle, expect_cycles);
        check_eq("done_count", done_cnt, 1);
        check_eq("enable_cycles", en_cnt, sum);
        check_eq("enable_to_done", done_cycle - last_hi, FW + 1);
        check_eq("valid_count", vld_cnt, total);
        check_eq("bc_left", exp_bc.size(), 0);
        check_eq("cells_left", exp_cells.size(), 0);
    endtask

    initial begin
        rst   = 1'b1;
        start = 1'b0;
        for (int c = 0; c < NCELLS; c++) counts[c] = 0;
        fill_mem();
        repeat (3) @(negedge clk);
        check_eq("rst_busy", out_busy, 1'b0);
        check_eq("rst_en", out_motion_update_enable, 1'b0);
        check_eq("rst_cell", out_rd_cell_id, 12'h111);
        check_eq("rst_rden", {out_rden, out_read_address}, 9'h0);
        check_eq("rst_bus", {out_data_valid, out_data_dst_cell, out_data, done}, 110'h0);
        rst = 1'b0;
        repeat (2) @(negedge clk);

        // Every cell holds linear index mod 5 particles.
        for (int c = 0; c < NCELLS; c++) counts[c] = c % 5;
        fill_mem();
        run_pass(1'b0);

        // All cells empty.
        for (int c = 0; c < NCELLS; c++) counts[c] = 0;
        fill_mem();
        run_pass(1'b0);

        // Random counts with a second start pulse inside the pass.
        for (int c = 0; c < NCELLS; c++) counts[c] = int'($urandom_range(0, 6));
        fill_mem();
        run_pass(1'b1);

        // Maximum count in the last cell, single particle in the first.
        for (int c = 0; c < NCELLS; c++) counts[c] = 0;
        counts[0]  = 1;
        counts[63] = 255;
        fill_mem();
        run_pass(1'b0);

        // Asynchronous reset in the middle of a particle burst.
        for (int c = 0; c < NCELLS; c++) counts[c] = int'($urandom_range(3, 8));
        fill_mem();
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        begin
            int k;
            for (k = 0; k < 200; k++) begin
                if (out_rden && out_read_address != 8'h0 && cidx(out_rd_cell_id) > 2) break;
                @(negedge clk);
            end
            check_eq("reach_read_particles", k < 200, 1'b1);
        end
        #2 rst = 1'b1;
        #1;
        check_eq("arst_busy", out_busy, 1'b0);
        check_eq("arst_en", out_motion_update_enable, 1'b0);
        check_eq("arst_cell", out_rd_cell_id, 12'h111);
        check_eq("arst_rden", {out_rden, out_read_address}, 9'h0);
        check_eq("arst_bus", {out_data_valid, out_data_dst_cell, out_data, done}, 110'h0);
        @(negedge clk);
        rst = 1'b0;
        repeat (3) @(negedge clk);
        for (int c = 0; c < NCELLS; c++) counts[c] = int'($urandom_range(0, 5));
        fill_mem();
        run_pass(1'b0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
